md_sched: RTL and testbench

//   Sequencer for the shared multiply/divide unit in stage E of the 5-stage pipeline.
//   - Accepts one mult/div/mthi/mtlo operation per start pulse and counts its latency.
//   - Holds the HI/LO architectural registers.
//   - Drives Busy to the hazard/stall logic, which holds any md-class instruction in D

---
 rtl/md_sched_if.sv | 20 ++
 rtl/md_sched.sv | 136 +++++++++++++
 tb/tb_md_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// Operation/result bundle between the E-stage issue logic and the md_sched sequencer.
interface md_sched_if;
  logic        E_MD_start;
  logic [3:0]  E_MD_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_MD_start, E_MD_op, E_rs_data, E_rt_data,
    input  Busy, HI, LO
  );

  modport slave (
    input  E_MD_start, E_MD_op, E_rs_data, E_rt_data,
    output Busy, HI, LO
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer: computes the result at issue, holds Busy for the op's
// latency, then commits into HI/LO. Define MD_SCHED_MADD_EN for madd/maddu/msub/msubu.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_SCHED_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   tmp_hi_q, tmp_lo_q;
  logic          tmp_wr_q;

  logic [31:0]   rs, rt;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   ua, ub, ub_safe, q_u, r_u, q_s, r_s;
  logic [63:0]   res_d;
  logic          long_d, wr_d;
  logic [CW-1:0] cyc_d;

  assign rs = md.E_rs_data;
  assign rt = md.E_rt_data;

  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'b0, rs} * {32'b0, rt};

  // Signed divide goes through magnitudes so 0x80000000 / -1 needs no special case.
  assign ua      = rs[31] ? (~rs + 32'd1) : rs;
  assign ub      = rt[31] ? (~rt + 32'd1) : rt;
  assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
  assign q_u     = ua / ub_safe;
  assign r_u     = ua % ub_safe;
  assign q_s     = (rs[31] ^ rt[31]) ? (~q_u + 32'd1) : q_u;
  assign r_s     = rs[31] ? (~r_u + 32'd1) : r_u;

  always_comb begin
    res_d  = '0;
    long_d = 1'b0;
    wr_d   = 1'b1;
    cyc_d  = CW'(MULT_CYCLES);
    case (md.E_MD_op)
      OP_MULT:  begin long_d = 1'b1; res_d = prod_s; end
      OP_MULTU: begin long_d = 1'b1; res_d = prod_u; end
      OP_DIV: begin
        long_d = 1'b1;
        cyc_d  = CW'(DIV_CYCLES);
        wr_d   = (rt != 32'd0);
        res_d  = {r_s, q_s};
      end
      OP_DIVU: begin
        long_d = 1'b1;
        cyc_d  = CW'(DIV_CYCLES);
        wr_d   = (rt != 32'd0);
        res_d  = {rs % ub_safe, rs / ub_safe};
      end
`ifdef MD_SCHED_MADD_EN
      OP_MADD:  begin long_d = 1'b1; res_d = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin long_d = 1'b1; res_d = {hi_q, lo_q} + prod_u; end
      OP_MSUB:  begin long_d = 1'b1; res_d = {hi_q, lo_q} - prod_s; end
      OP_MSUBU: begin long_d = 1'b1; res_d = {hi_q, lo_q} - prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      tmp_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.E_MD_start) begin
            if (long_d) begin
              tmp_hi_q <= res_d[63:32];
              tmp_lo_q <= res_d[31:0];
              tmp_wr_q <= wr_d;
              cnt_q    <= cyc_d;
              busy_q   <= 1'b1;
              state_q  <= BUSY;
            end else if (md.E_MD_op == OP_MTHI) begin
              hi_q <= rs;
            end else if (md.E_MD_op == OP_MTLO) begin
              lo_q <= rs;
            end
          end
        end
        BUSY: begin
          // Starts arriving here (including on the commit edge) are dropped.
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (tmp_wr_q) begin
              hi_q <= tmp_hi_q;
              lo_q <= tmp_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.Busy = busy_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: latency, arithmetic corner cases, ignored starts, reset abort.
module tb_md_sched;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  md_sched_if bus ();
  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.E_MD_start = 1'b1;
    bus.E_MD_op    = op;
    bus.E_rs_data  = a;
    bus.E_rt_data  = b;
    step();
    bus.E_MD_start = 1'b0;
    bus.E_MD_op    = 4'd0;
  endtask

  // Issue a long op, require Busy for exactly n cycles, then check committed HI/LO.
  task automatic long_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] ehi, input logic [31:0] elo);
    int nb;
    issue(op, a, b);
    nb = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.Busy === 1'b1) nb++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(n));
    chk({tag, "_busy_end"}, {31'b0, bus.Busy}, 32'd0);
    chk({tag, "_hi"}, bus.HI, ehi);
    chk({tag, "_lo"}, bus.LO, elo);
  endtask

  initial begin
    int nb;
    bus.E_MD_start = 1'b0;
    bus.E_MD_op    = 4'd0;
    bus.E_rs_data  = '0;
    bus.E_rt_data  = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);

    long_op("mult",   4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    long_op("multu",  4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    long_op("mult_nn",4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h0, 32'h1);
    long_op("div",    4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    long_op("divu0",  4'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    long_op("div_pn", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h1, 32'hFFFFFFFD);
    long_op("div_ovf",4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    long_op("divu",   4'd4, 32'hFFFFFFFF, 32'h10, 10, 32'hF, 32'h0FFFFFFF);

    issue(4'd5, 32'h1234, 32'h0);
    chk("mthi_hi", bus.HI, 32'h1234);
    chk("mthi_busy", {31'b0, bus.Busy}, 32'd0);
    issue(4'd6, 32'h5678, 32'h0);
    chk("mtlo_lo", bus.LO, 32'h5678);
    chk("mtlo_hi", bus.HI, 32'h1234);

    // DIV 100/7, with a second DIV at cycle 3 and an MTLO on the commit cycle.
    issue(4'd3, 32'd100, 32'd7);
    nb = 0;
    for (int i = 1; i <= 10; i++) begin
      if (bus.Busy === 1'b1) nb++;
      if (i == 3) begin
        bus.E_MD_start = 1'b1; bus.E_MD_op = 4'd3;
        bus.E_rs_data = 32'd50; bus.E_rt_data = 32'd5;
      end else if (i == 10) begin
        bus.E_MD_start = 1'b1; bus.E_MD_op = 4'd6;
        bus.E_rs_data = 32'hAAAA;
      end
      step();
      bus.E_MD_start = 1'b0; bus.E_MD_op = 4'd0;
    end
    chk("ign_busy_cycles", 32'(nb), 32'd10);
    chk("ign_hi", bus.HI, 32'd2);
    chk("ign_lo", bus.LO, 32'd14);
    step();
    chk("ign_no_restart", {31'b0, bus.Busy}, 32'd0);

    issue(4'd15, 32'h9999, 32'h1);
    chk("undef15_busy", {31'b0, bus.Busy}, 32'd0);
    issue(4'd0, 32'h9999, 32'h1);
    chk("none_busy", {31'b0, bus.Busy}, 32'd0);
    chk("none_hi", bus.HI, 32'd2);
    chk("none_lo", bus.LO, 32'd14);

`ifdef MD_SCHED_MADD_EN
    issue(4'd5, 32'h0, 32'h0);
    issue(4'd6, 32'hFFFFFFFF, 32'h0);
    long_op("maddu", 4'd8, 32'd1, 32'd1, 5, 32'h1, 32'h0);
    long_op("msub",  4'd9, 32'd1, 32'd2, 5, 32'h0, 32'hFFFFFFFE);
`else
    issue(4'd8, 32'd1, 32'd1);
    chk("op8_busy", {31'b0, bus.Busy}, 32'd0);
    step(); step(); step(); step(); step();
    chk("op8_hi", bus.HI, 32'd2);
    chk("op8_lo", bus.LO, 32'd14);
`endif

    // Reset during the third Busy cycle of a DIV.
    issue(4'd3, 32'd9, 32'd2);
    step(); step();
    chk("abort_busy_pre", {31'b0, bus.Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'b0, bus.Busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("abort_late_busy", {31'b0, bus.Busy}, 32'd0);
    chk("abort_late_hi", bus.HI, 32'd0);
    chk("abort_late_lo", bus.LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
